// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding, read-length limits and the request length clamp
// for the i2c register sequencer.
package i2c_seq_pkg;

    localparam int MAX_RD_BYTES = 4;
    localparam int LEN_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_STOP, DONE} state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) :
               (len > LEN_W'(MAX_RD_BYTES)) ? LEN_W'(MAX_RD_BYTES) : len;
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if: request/response channel plus i2c_master handshake signals;
// the slave modport is the sequencer side, the master modport the client/bus side.
interface i2c_reg_sequencer_if;
    import i2c_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic [6:0]       req_dev;
    logic [7:0]       req_reg;
    logic [7:0]       req_wdata;
    logic [LEN_W-1:0] req_len;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             rsp_timeout;
    logic             m_ena;
    logic             m_rw;
    logic [6:0]       m_addr;
    logic [7:0]       m_data_wr;
    logic             m_busy;
    logic             m_ack_error;
    logic [7:0]       m_data_rd;

    modport slave (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata, req_len,
        input  m_busy, m_ack_error, m_data_rd,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        output m_ena, m_rw, m_addr, m_data_wr
    );

    modport master (
        output req_valid, req_rw, req_dev, req_reg, req_wdata, req_len,
        output m_busy, m_ack_error, m_data_rd,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        input  m_ena, m_rw, m_addr, m_data_wr
    );

endinterface

// File: rtl/i2c_busy_edge.sv
// i2c_busy_edge: registers the master's busy flag and flags its rising and falling edges.
module i2c_busy_edge (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic rise,
    output logic fall
);

    logic busy_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) busy_q <= 1'b0;
        else        busy_q <= busy;

    assign rise = busy & ~busy_q;
    assign fall = ~busy & busy_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register write / 1-4 byte register read into the i2c_master handshake.
// Define I2C_SEQ_TIMEOUT_EN to abort after TIMEOUT_CYCLES clocks without an m_busy edge.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
`ifdef I2C_SEQ_TIMEOUT_EN
    #(parameter int TIMEOUT_CYCLES = 2000000)
`endif
(
    input logic                clk,
    input logic                reset,
    i2c_reg_sequencer_if.slave bus
);

    state_t           state;
    logic             rise, fall, lat_rw, err, tmo;
    logic [7:0]       lat_wdata;
    logic [LEN_W-1:0] lat_len, rise_cnt, got, rise_nx, got_nx;

    i2c_busy_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .busy  (bus.m_busy),
        .rise  (rise),
        .fall  (fall)
    );

    assign bus.req_ready = state == IDLE && !bus.m_busy;
    assign rise_nx = (rise_cnt == '1) ? rise_cnt : rise_cnt + 1'b1;
    assign got_nx  = (got == LEN_W'(MAX_RD_BYTES)) ? got : got + 1'b1;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tcnt;
    logic          tflag;

    assign tmo = (state == RUN || state == WAIT_STOP) && tcnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tcnt            <= '0;
            tflag           <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            tcnt            <= (state == IDLE || rise || fall) ? '0 : tcnt + 1'b1;
            tflag           <= (state == IDLE) ? 1'b0 : tflag | tmo;
            bus.rsp_timeout <= state == DONE && tflag;
        end
`else
    assign tmo = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= IDLE;
            lat_rw        <= 1'b0;
            lat_wdata     <= '0;
            lat_len       <= '0;
            rise_cnt      <= '0;
            got           <= '0;
            err           <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.m_ena     <= 1'b0;
            bus.m_rw      <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_data_wr <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    lat_rw        <= bus.req_rw;
                    lat_wdata     <= bus.req_wdata;
                    lat_len       <= clamp_len(bus.req_len);
                    rise_cnt      <= '0;
                    got           <= '0;
                    err           <= 1'b0;
                    bus.rsp_data  <= '0;
                    bus.rsp_err   <= 1'b0;
                    bus.m_ena     <= 1'b1;
                    bus.m_rw      <= 1'b0;
                    bus.m_addr    <= bus.req_dev;
                    bus.m_data_wr <= bus.req_reg;
                    state         <= RUN;
                end
                RUN: if (tmo) begin
                    err       <= 1'b1;
                    bus.m_ena <= 1'b0;
                    state     <= DONE;
                end else if (bus.m_ack_error) begin
                    // an error coinciding with the closing fall skips the stop wait
                    err       <= 1'b1;
                    bus.m_ena <= 1'b0;
                    state     <= fall ? DONE : WAIT_STOP;
                end else if (rise) begin
                    rise_cnt <= rise_nx;
                    if (!lat_rw) begin
                        if (rise_nx == LEN_W'(1)) bus.m_data_wr <= lat_wdata;
                        if (rise_nx == LEN_W'(2)) begin
                            bus.m_ena <= 1'b0;
                            state     <= WAIT_STOP;
                        end
                    end else begin
                        if (rise_nx == LEN_W'(1)) bus.m_rw <= 1'b1;
                        // releasing ena during the last byte makes the master NACK it and stop
                        if (rise_nx == lat_len + 1'b1) bus.m_ena <= 1'b0;
                    end
                end else if (fall && lat_rw && rise_cnt >= LEN_W'(2)) begin
                    bus.rsp_data <= {bus.rsp_data[23:0], bus.m_data_rd};
                    got          <= got_nx;
                    if (got_nx == lat_len) state <= DONE;
                end
                WAIT_STOP: if (tmo) begin
                    err       <= 1'b1;
                    bus.m_ena <= 1'b0;
                    state     <= DONE;
                end else if (fall) begin
                    state <= DONE;
                end
                DONE: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= err;
                    bus.m_ena     <= 1'b0;
                    if (err) bus.rsp_data <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: transaction-level i2c_master model plus reference checks for the sequencer
module tb_i2c_reg_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_d = '0;
  logic        rsp_e = 1'b0;
  logic        rsp_t = 1'b0;
  logic [7:0]  slave_mem [4];
  logic [7:0]  byte_log [$];
  logic        ack_log [$];

  always #5 clk = ~clk;

  i2c_reg_sequencer_if bus ();

`ifdef I2C_SEQ_TIMEOUT_EN
  i2c_reg_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`else
  i2c_reg_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`endif

  always @(negedge clk)
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_d   <= bus.rsp_data;
      rsp_e   <= bus.rsp_err;
      rsp_t   <= bus.rsp_timeout;
    end

  function automatic logic [39:0] packed_bytes();
    logic [39:0] p = '0;
    foreach (byte_log[i]) p[31:0] = {p[23:0], byte_log[i]};
    p[39:32] = 8'(byte_log.size());
    return p;
  endfunction

  function automatic logic [7:0] packed_acks();
    logic [7:0] a = '0;
    foreach (ack_log[i]) a[3:0] = {a[2:0], ack_log[i]};
    a[7:4] = 4'(ack_log.size());
    return a;
  endfunction

  function automatic logic [51:0] out_vec();
    return {bus.m_ena, bus.m_rw, bus.m_addr, bus.m_data_wr, bus.rsp_valid,
            bus.rsp_data, bus.rsp_err, bus.rsp_timeout};
  endfunction

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [2:0] len);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    bus.req_len   = len;
    while (bus.req_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", bus.req_ready, t);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic master_run(input bit present, input bit simul);
    int   t = 0;
    int   idx = 0;
    logic cur_rw;
    while (bus.m_ena !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (bus.m_ena !== 1'b1) begin
      errors++;
      $display("FAIL master_start: m_ena=%b, required 1", bus.m_ena);
      return;
    end
    cur_rw = bus.m_rw;
    byte_log.push_back({bus.m_addr, bus.m_rw});
    bus.m_busy = 1'b1;
    if (!present) begin
      repeat (4) @(negedge clk);
      bus.m_ack_error = 1'b1;
      if (!simul) repeat (3) @(negedge clk);
      bus.m_busy = 1'b0;
      repeat (2) @(negedge clk);
      bus.m_ack_error = 1'b0;
      return;
    end
    for (int b = 0; b < 8; b++) begin
      if (!cur_rw) byte_log.push_back(bus.m_data_wr);
      repeat (6) @(negedge clk);
      if (cur_rw) begin
        bus.m_data_rd = slave_mem[idx];
        if (idx < 3) idx++;
        ack_log.push_back(bus.m_ena);
      end
      bus.m_busy = 1'b0;
      repeat (2) @(negedge clk);
      if (bus.m_ena !== 1'b1) break;
      if (bus.m_rw != cur_rw) begin
        cur_rw = bus.m_rw;
        byte_log.push_back({bus.m_addr, bus.m_rw});
      end
      bus.m_busy = 1'b1;
    end
    bus.m_busy = 1'b0;
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [2:0] len,
                         input bit present, input bit simul, output int pulses);
    int c0, t;
    byte_log.delete();
    ack_log.delete();
    c0 = rsp_cnt;
    t = 0;
    fork
      send_req(rw, dev, rg, wd, len);
      master_run(present, simul);
    join
    while (rsp_cnt == c0 && t < 300) begin @(posedge clk); t++; end
    checks++;
    if (rsp_cnt == c0) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles, required one", t);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    pulses = rsp_cnt - c0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = '0; bus.req_reg = '0;
    bus.req_wdata = '0; bus.req_len = '0; bus.m_ack_error = 1'b0; bus.m_data_rd = '0;
    bus.m_busy = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", out_vec()); end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: req_ready=%b, required 0", bus.req_ready); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_busy: req_ready=%b while busy, required 0", bus.req_ready); end
    bus.m_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: req_ready=%b, required 1", bus.req_ready); end
  endtask

  task automatic test_write();
    int p;
    run_txn(1'b0, 7'h48, 8'h01, 8'hA5, 3'd0, 1'b1, 1'b0, p);
    checks++;
    if (packed_bytes() !== {8'd3, 32'h0090_01A5}) begin errors++; $display("FAIL write_bytes: got %h, required %h", packed_bytes(), {8'd3, 32'h0090_01A5}); end
    checks++;
    if (p !== 1) begin errors++; $display("FAIL write_pulses: got %0d, required 1", p); end
    checks++;
    if ({rsp_e, rsp_t, rsp_d} !== 34'd0) begin errors++; $display("FAIL write_rsp: err=%b to=%b data=%h, required 0 0 0", rsp_e, rsp_t, rsp_d); end
  endtask

  task automatic test_read2();
    int p;
    slave_mem = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_txn(1'b1, 7'h48, 8'h00, 8'h00, 3'd2, 1'b1, 1'b0, p);
    checks++;
    if (packed_bytes() !== {8'd3, 32'h0090_0091}) begin errors++; $display("FAIL read2_bytes: got %h, required %h", packed_bytes(), {8'd3, 32'h0090_0091}); end
    checks++;
    if (packed_acks() !== 8'h22) begin errors++; $display("FAIL read2_acks: got %h, required 22", packed_acks()); end
    checks++;
    if (rsp_d !== 32'h0000_1234 || rsp_e !== 1'b0 || p !== 1) begin errors++; $display("FAIL read2_rsp: data=%h err=%b pulses=%0d, required 00001234 0 1", rsp_d, rsp_e, p); end
  endtask

  task automatic test_addr_nack();
    int p;
    for (int s = 0; s < 2; s++) begin
      run_txn(1'b0, 7'h50, 8'h02, 8'h33, 3'd0, 1'b0, s[0], p);
      checks++;
      if (packed_bytes() !== {8'd1, 32'h0000_00A0}) begin errors++; $display("FAIL nack_bytes(simul=%0d): got %h, required 01000000a0", s, packed_bytes()); end
      checks++;
      if ({rsp_e, rsp_t, rsp_d} !== {1'b1, 33'd0} || p !== 1) begin errors++; $display("FAIL nack_rsp(simul=%0d): err=%b to=%b data=%h pulses=%0d, required 1 0 0 1", s, rsp_e, rsp_t, rsp_d, p); end
    end
  endtask

  task automatic test_len_clamp();
    int p;
    slave_mem = '{8'h7E, 8'hAA, 8'hBB, 8'hCC};
    run_txn(1'b1, 7'h21, 8'h07, 8'h00, 3'd0, 1'b1, 1'b0, p);
    checks++;
    if (rsp_d !== 32'h0000_007E || packed_acks() !== 8'h10 || p !== 1) begin errors++; $display("FAIL clamp_len0: data=%h acks=%h pulses=%0d, required 0000007e 10 1", rsp_d, packed_acks(), p); end
    slave_mem = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_txn(1'b1, 7'h21, 8'h08, 8'h00, 3'd7, 1'b1, 1'b0, p);
    checks++;
    if (rsp_d !== 32'hDEAD_BEEF || packed_acks() !== 8'h4E || p !== 1) begin errors++; $display("FAIL clamp_len7: data=%h acks=%h pulses=%0d, required deadbeef 4e 1", rsp_d, packed_acks(), p); end
  endtask

  task automatic test_random();
    int          p, n;
    logic        rw, present, simul;
    logic [6:0]  dev;
    logic [7:0]  rg, wd;
    logic [2:0]  len;
    logic [39:0] exp_b;
    logic [31:0] exp_d;
    logic [7:0]  exp_a;
    logic        exp_e;
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom_range(0, 1));
      present = $urandom_range(0, 3) != 0;
      simul = 1'($urandom_range(0, 1));
      dev = 7'($urandom_range(0, 127));
      rg = 8'($urandom_range(0, 255));
      wd = 8'($urandom_range(0, 255));
      len = 3'($urandom_range(0, 7));
      foreach (slave_mem[k]) slave_mem[k] = 8'($urandom_range(0, 255));
      n = (len == 0) ? 1 : (len > 4) ? 4 : int'(len);
      exp_d = '0;
      exp_a = '0;
      exp_e = 1'b0;
      if (!present) begin
        exp_b = {8'd1, 24'd0, dev, 1'b0};
        exp_e = 1'b1;
      end else if (!rw) begin
        exp_b = {8'd3, 8'd0, dev, 1'b0, rg, wd};
      end else begin
        exp_b = {8'd3, 8'd0, dev, 1'b0, rg, dev, 1'b1};
        for (int k = 0; k < n; k++) exp_d = (exp_d << 8) | 32'(slave_mem[k]);
        exp_a = {4'(n), 4'(((1 << n) - 1) & ~1)};
      end
      run_txn(rw, dev, rg, wd, len, present, simul, p);
      checks++;
      if (packed_bytes() !== exp_b || packed_acks() !== exp_a) begin errors++; $display("FAIL rand%0d_bus: bytes=%h acks=%h, required %h %h", i, packed_bytes(), packed_acks(), exp_b, exp_a); end
      checks++;
      if (rsp_d !== exp_d || rsp_e !== exp_e || rsp_t !== 1'b0 || p !== 1) begin errors++; $display("FAIL rand%0d_rsp: data=%h err=%b to=%b pulses=%0d, required %h %b 0 1", i, rsp_d, rsp_e, rsp_t, p, exp_d, exp_e); end
    end
  endtask

  task automatic test_reset_mid_read();
    int c0, p;
    c0 = rsp_cnt;
    send_req(1'b1, 7'h48, 8'h10, 8'h00, 3'd4);
    bus.m_busy = 1'b1;
    repeat (6) @(negedge clk);
    bus.m_busy = 1'b0;
    repeat (2) @(negedge clk);
    bus.m_busy = 1'b1;
    repeat (6) @(negedge clk);
    bus.m_data_rd = 8'h55;
    bus.m_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.m_ena !== 1'b1 || bus.m_rw !== 1'b1) begin errors++; $display("FAIL midread_active: ena=%b rw=%b, required 1 1", bus.m_ena, bus.m_rw); end
    #2 reset = 1'b0;
    bus.m_busy = 1'b1;
    #1;
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL midread_reset_outputs: got %h, required 0", out_vec()); end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL midread_reset_ready: req_ready=%b, required 0", bus.req_ready); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.m_busy = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_cnt != c0) begin errors++; $display("FAIL midread_no_rsp: %0d pulses, required 0", rsp_cnt - c0); end
    slave_mem = '{8'h9C, 8'h00, 8'h00, 8'h00};
    run_txn(1'b1, 7'h48, 8'h10, 8'h00, 3'd1, 1'b1, 1'b0, p);
    checks++;
    if (rsp_d !== 32'h0000_009C || rsp_e !== 1'b0 || p !== 1) begin errors++; $display("FAIL after_reset_read: data=%h err=%b pulses=%0d, required 0000009c 0 1", rsp_d, rsp_e, p); end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    int c0;
    c0 = rsp_cnt;
    send_req(1'b0, 7'h48, 8'h05, 8'h66, 3'd0);
    bus.m_busy = 1'b1;
    @(negedge clk);
    while (bus.m_ena === 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (k != 100) begin errors++; $display("FAIL timeout_ena_drop: after %0d cycles, required 100", k); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_cnt - c0 != 1 || rsp_e !== 1'b1 || rsp_t !== 1'b1 || rsp_d !== '0) begin errors++; $display("FAIL timeout_rsp: pulses=%0d err=%b to=%b data=%h, required 1 1 1 0", rsp_cnt - c0, rsp_e, rsp_t, rsp_d); end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL timeout_ready: req_ready=%b while busy, required 0", bus.req_ready); end
    bus.m_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read2();
    test_addr_nack();
    test_len_clamp();
    test_random();
    test_reset_mid_read();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
